noc_port_requester: RTL and testbench

//  Requester side of the router port arbitration handshake: buffers flits from one input

---
 rtl/noc_flit_pkg.sv | 24 ++
 rtl/noc_flit_fifo.sv | 54 +++++
 rtl/noc_port_requester.sv | 178 +++++++++++++++++
 tb/tb_noc_port_requester.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared flit encodings, requester state type and small helpers for the
// NoC port requester.
package noc_flit_pkg;

    localparam logic [2:0] FLIT_NONE   = 3'b000;
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_STALLED = 2'd3
    } req_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous show-ahead flit FIFO: o_head always presents the oldest entry.
// A push into a full FIFO is ignored even when a pop happens the same cycle.
module noc_flit_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_port_requester.sv
// Requester side of the router port arbitration handshake. Buffers one input
// channel, requests the port from the arbiter and forwards flits while granted.
// Optional packet length checker (len_err output) enabled by NOC_REQ_LEN_CHECK_EN.
module noc_port_requester
    import noc_flit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_flit_id,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        req_flit_id,
    output logic [LEN_W-1:0]  req_length,
    output logic              out_valid,
    output logic [2:0]        out_flit_id,
    output logic [DATA_W-1:0] out_data,
`ifdef NOC_REQ_LEN_CHECK_EN
    output logic              len_err,
`endif
    output logic              proto_err
);
    req_state_e          r_state;
    req_state_e          w_state_nxt;
    logic [LEN_W-1:0]    r_req_length;
    logic                r_out_valid;
    logic [2:0]          r_out_flit_id;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_proto_err;

    logic [DATA_W+2:0]   w_head;
    logic [2:0]          w_head_id;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_fwd;
    logic                w_hdr_pop;
    logic                w_latch_len;
    logic                w_set_perr;
    logic [2:0]          w_req_flit_id;

    noc_flit_fifo #(.W(DATA_W + 3), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_din   ({in_flit_id, in_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_id   = w_head[DATA_W+2:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];
    assign in_ready    = ~w_full;
    assign req         = (r_state != ST_IDLE);
    assign req_flit_id = w_req_flit_id;
    assign req_length  = r_req_length;
    assign out_valid   = r_out_valid;
    assign out_flit_id = r_out_flit_id;
    assign out_data    = r_out_data;
    assign proto_err   = r_proto_err;

    // Next-state, pop and error decisions. A header reaching the head while a
    // packet is still open means its tail was lost: re-request for the new packet.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_fwd         = 1'b0;
        w_hdr_pop     = 1'b0;
        w_latch_len   = 1'b0;
        w_set_perr    = 1'b0;
        w_req_flit_id = FLIT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_head_id == FLIT_HEADER) begin
                        w_latch_len = 1'b1;
                        w_state_nxt = ST_REQUEST;
                    end else begin
                        w_pop      = 1'b1;
                        w_set_perr = 1'b1;
                    end
                end
            end
            ST_REQUEST: begin
                w_req_flit_id = FLIT_HEADER;
                if (grant && !w_empty) begin
                    w_pop       = 1'b1;
                    w_fwd       = 1'b1;
                    w_hdr_pop   = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_req_flit_id = w_empty ? FLIT_NONE : w_head_id;
                if (!w_empty && w_head_id == FLIT_HEADER) begin
                    w_set_perr  = 1'b1;
                    w_latch_len = 1'b1;
                    w_state_nxt = ST_REQUEST;
                end else if (!grant) begin
                    w_state_nxt = ST_STALLED;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                    w_fwd = 1'b1;
                    if (w_head_id == FLIT_TAIL) w_state_nxt = ST_IDLE;
                end
            end
            ST_STALLED: begin
                w_req_flit_id = FLIT_BODY;
                if (!w_empty && w_head_id == FLIT_HEADER) begin
                    w_set_perr  = 1'b1;
                    w_latch_len = 1'b1;
                    w_state_nxt = ST_REQUEST;
                end else if (grant) begin
                    w_state_nxt = ST_ACTIVE;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        w_fwd = 1'b1;
                        if (w_head_id == FLIT_TAIL) w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, length latch, forwarded-flit register and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_length  <= '0;
            r_out_valid   <= 1'b0;
            r_out_flit_id <= '0;
            r_out_data    <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_fwd;
            if (w_latch_len) r_req_length <= w_head_data[LEN_W-1:0];
            if (w_fwd) begin
                r_out_flit_id <= w_head_id;
                r_out_data    <= w_head_data;
            end
            if (w_set_perr) r_proto_err <= 1'b1;
        end
    end

`ifdef NOC_REQ_LEN_CHECK_EN
    logic [LEN_W-1:0] r_len_cnt;
    logic [LEN_W-1:0] w_len_cnt_inc;
    logic             r_len_err;

    assign w_len_cnt_inc = len_sat_inc(r_len_cnt);
    assign len_err       = r_len_err;

    // Count forwarded flits of the current packet (header counts as one) and
    // compare against the advertised length when the tail leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_cnt <= '0;
            r_len_err <= 1'b0;
        end else if (w_hdr_pop) begin
            r_len_cnt <= LEN_W'(1);
        end else if (w_fwd) begin
            r_len_cnt <= w_len_cnt_inc;
            if (w_head_id == FLIT_TAIL && w_len_cnt_inc != r_req_length) r_len_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_port_requester.sv
// Directed bench for noc_port_requester: table of per-cycle vectors plus
// hand-written full-FIFO and (optionally) length-check sequences.
module tb_noc_port_requester;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b100;
    localparam logic [2:0] N = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_flit_id;
    logic [31:0] in_data;
    logic        grant;
    logic        req;
    logic [2:0]  req_flit_id;
    logic [11:0] req_length;
    logic        out_valid;
    logic [2:0]  out_flit_id;
    logic [31:0] out_data;
    logic        proto_err;
`ifdef NOC_REQ_LEN_CHECK_EN
    logic        len_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noc_port_requester #(.DATA_W(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_flit_id  (in_flit_id),
        .in_data     (in_data),
        .grant       (grant),
        .req         (req),
        .req_flit_id (req_flit_id),
        .req_length  (req_length),
        .out_valid   (out_valid),
        .out_flit_id (out_flit_id),
        .out_data    (out_data),
`ifdef NOC_REQ_LEN_CHECK_EN
        .len_err     (len_err),
`endif
        .proto_err   (proto_err)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  id;
        logic [31:0] data;
        logic        grant;
        logic        e_req;
        logic [2:0]  e_rfid;
        logic        e_ovld;
        logic [2:0]  e_oid;
        logic [31:0] e_odata;
        logic        e_rdy;
        logic        e_perr;
        logic [11:0] e_len;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(input logic r, input logic vld, input logic [2:0] id,
                               input logic [31:0] d, input logic g, input logic er,
                               input logic [2:0] erf, input logic eov, input logic [2:0] eoid,
                               input logic [31:0] eod, input logic erdy, input logic eperr,
                               input logic [11:0] elen);
        vec_t v;
        v.rst = r; v.vld = vld; v.id = id; v.data = d; v.grant = g;
        v.e_req = er; v.e_rfid = erf; v.e_ovld = eov; v.e_oid = eoid; v.e_odata = eod;
        v.e_rdy = erdy; v.e_perr = eperr; v.e_len = elen;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [2:0] id, input logic [31:0] d, input logic g);
        in_valid = vld; in_flit_id = id; in_data = d; grant = g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, N, 32'h0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    // Pushes an n-flit packet with grant held high, then idles to drain.
    task automatic send_pkt(input logic [11:0] len, input int nflits);
        int pi = 0;
        for (int c = 0; c < nflits + 10; c++) begin
            if (pi < nflits)
                drive(1'b1, (pi == 0) ? H : ((pi == nflits - 1) ? T : B),
                      (pi == 0) ? {20'h70000, len} : 32'h70 + pi, 1'b1);
            else
                drive(1'b0, N, 32'h0, 1'b1);
            if (in_valid && in_ready) pi++;
            step();
        end
    endtask

    initial begin
        logic [2:0]  exp_id [8];
        logic [31:0] exp_d  [8];
        int          pi;
        int          oi;
        int          gaps;
        logic        acc;

        // Single-packet forwarding
        vq.push_back(V(0,1,H,32'hA0000003,0, 0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,B,32'hB0000001,0, 1,H,0,N,0, 1,0,12'd3));
        vq.push_back(V(0,1,T,32'hC0000002,1, 1,B,1,H,32'hA0000003, 1,0,12'd3));
        vq.push_back(V(0,0,N,0,1,            1,T,1,B,32'hB0000001, 1,0,12'd3));
        vq.push_back(V(0,0,N,0,1,            0,N,1,T,32'hC0000002, 1,0,12'd3));
        vq.push_back(V(0,0,N,0,0,            0,N,0,N,0, 1,0,12'd3));
        // Grant loss and recovery
        vq.push_back(V(1,0,N,0,0,            0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,H,32'h10000005,0, 0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,B,32'h11,0,       1,H,0,N,0, 1,0,12'd5));
        vq.push_back(V(0,1,B,32'h12,1,       1,B,1,H,32'h10000005, 1,0,12'd5));
        vq.push_back(V(0,1,B,32'h13,1,       1,B,1,B,32'h11, 1,0,12'd5));
        vq.push_back(V(0,1,T,32'h14,1,       1,B,1,B,32'h12, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,0,            1,B,0,N,0, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,0,            1,B,0,N,0, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,0,            1,B,0,N,0, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,0,            1,B,0,N,0, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,1,            1,T,1,B,32'h13, 1,0,12'd5));
        vq.push_back(V(0,0,N,0,1,            0,N,1,T,32'h14, 1,0,12'd5));
        // Stray body while idle, then a valid packet
        vq.push_back(V(1,0,N,0,0,            0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,B,32'h21,0,       0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,0,N,0,0,            0,N,0,N,0, 1,1,12'd0));
        vq.push_back(V(0,1,H,32'h30000002,0, 0,N,0,N,0, 1,1,12'd0));
        vq.push_back(V(0,1,T,32'h31,0,       1,H,0,N,0, 1,1,12'd2));
        vq.push_back(V(0,0,N,0,1,            1,T,1,H,32'h30000002, 1,1,12'd2));
        vq.push_back(V(0,0,N,0,1,            0,N,1,T,32'h31, 1,1,12'd2));
        // Reset mid-packet with two flits buffered, then a clean packet
        vq.push_back(V(0,1,H,32'h40000004,0, 0,N,0,N,0, 1,1,12'd2));
        vq.push_back(V(0,1,B,32'h41,0,       1,H,0,N,0, 1,1,12'd4));
        vq.push_back(V(0,1,B,32'h42,1,       1,B,1,H,32'h40000004, 1,1,12'd4));
        vq.push_back(V(1,0,N,0,1,            0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,0,N,0,1,            0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,H,32'h50000002,1, 0,N,0,N,0, 1,0,12'd0));
        vq.push_back(V(0,1,T,32'h51,1,       1,H,0,N,0, 1,0,12'd2));
        vq.push_back(V(0,0,N,0,1,            1,T,1,H,32'h50000002, 1,0,12'd2));
        vq.push_back(V(0,0,N,0,1,            0,N,1,T,32'h51, 1,0,12'd2));
        vq.push_back(V(0,0,N,0,0,            0,N,0,N,0, 1,0,12'd2));

        // Reset values
        rst = 1'b1;
        drive(1'b0, N, 32'h0, 1'b0);
        step();
        step();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_flit_id", {29'd0, out_flit_id}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_req_length", {20'd0, req_length}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            drive(vq[i].vld, vq[i].id, vq[i].data, vq[i].grant);
            step();
            chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vq[i].e_req});
            chk($sformatf("v%0d_req_flit_id", i), {29'd0, req_flit_id}, {29'd0, vq[i].e_rfid});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vq[i].e_ovld});
            if (vq[i].e_ovld) begin
                chk($sformatf("v%0d_out_flit_id", i), {29'd0, out_flit_id}, {29'd0, vq[i].e_oid});
                chk($sformatf("v%0d_out_data", i), out_data, vq[i].e_odata);
            end
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vq[i].e_rdy});
            chk($sformatf("v%0d_proto_err", i), {31'd0, proto_err}, {31'd0, vq[i].e_perr});
            chk($sformatf("v%0d_req_length", i), {20'd0, req_length}, {20'd0, vq[i].e_len});
        end
        rst = 1'b0;

        // Full FIFO with grant withheld, then an 8-flit packet drained in order
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp_id[k] = (k == 0) ? H : ((k == 7) ? T : B);
            exp_d[k]  = (k == 0) ? 32'h60000008 : 32'h60 + k;
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, exp_id[k], exp_d[k], 1'b0);
            step();
        end
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_req", {31'd0, req}, 32'd1);
        chk("full_no_out", {31'd0, out_valid}, 32'd0);
        pi = 4;
        oi = 0;
        gaps = 0;
        for (int c = 0; c < 30 && oi < 8; c++) begin
            if (pi < 8) drive(1'b1, exp_id[pi], exp_d[pi], 1'b1);
            else        drive(1'b0, N, 32'h0, 1'b1);
            acc = in_valid & in_ready;
            step();
            if (acc) pi++;
            if (c == 0) chk("full_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
            if (out_valid) begin
                chk($sformatf("burst%0d_id", oi), {29'd0, out_flit_id}, {29'd0, exp_id[oi]});
                chk($sformatf("burst%0d_data", oi), out_data, exp_d[oi]);
                oi++;
            end else if (oi > 0) begin
                gaps++;
            end
        end
        chk("burst_count", oi, 8);
        chk("burst_gaps", gaps, 0);
        drive(1'b0, N, 32'h0, 1'b1);
        step();
        chk("burst_req_drop", {31'd0, req}, 32'd0);

`ifdef NOC_REQ_LEN_CHECK_EN
        do_reset();
        step();
        chk("len_err_reset", {31'd0, len_err}, 32'd0);
        send_pkt(12'd5, 4);
        chk("len_err_short_pkt", {31'd0, len_err}, 32'd1);
        do_reset();
        send_pkt(12'd4, 4);
        chk("len_err_exact_pkt", {31'd0, len_err}, 32'd0);
        chk("len_req_length", {20'd0, req_length}, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
